adc_rx_multi: RTL and testbench

//  Parametrised multi-channel serial ADC receiver (ADCS7476/PmodAD1-style frames), successor to the single-channel receiver.

---
 rtl/adc_rx_multi.sv | 83 ++++++++
 tb/tb_adc_rx_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adc_rx_multi.sv
// adc_rx_multi: NCH-channel serial ADC frame receiver with valid/ack output; ADC_RX_OVERRUN_EN enables sticky overrun
module adc_rx_multi #(
  parameter int DATA_W = 12,
  parameter int FRAME_LEN = 16,
  parameter int NCH = 2,
  parameter int GAP = 1
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic [NCH-1:0]          sdata,
  input  logic                    rx_en,
  input  logic                    cont,
  input  logic                    ack,
  output logic                    cs,
  output logic [NCH*DATA_W-1:0]   dout,
  output logic                    dout_valid,
  output logic                    rx_done_tick,
  output logic                    busy,
  output logic                    overrun
);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam int BW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  if (DATA_W > FRAME_LEN || FRAME_LEN > 64 || GAP < 1 || NCH < 1) begin : g_bad_params
    $error("adc_rx_multi: illegal parameter combination");
  end
  typedef enum logic [1:0] {IDLE, QUIET, SHIFT, DONE} state_t;
  state_t state;
  logic [GW-1:0] gap_cnt;
  logic [BW-1:0] bit_cnt;
  logic [NCH*DATA_W-1:0] sh, nxt;
  assign cs = state != SHIFT;
  assign busy = state != IDLE;
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NCH; i++) nxt[i*DATA_W +: DATA_W] = DATA_W'({sh[i*DATA_W +: DATA_W], sdata[i]});
  end
  // the result is captured on the last shift edge so dout, dout_valid and the tick appear together in DONE
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= IDLE;
      gap_cnt <= '0;
      bit_cnt <= '0;
      sh <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      if (ack && state != DONE) dout_valid <= 1'b0;
      case (state)
        IDLE: if (rx_en || cont) begin
          state <= QUIET;
          gap_cnt <= '0;
        end
        QUIET: if (gap_cnt == GW'(GAP - 1)) begin
          state <= SHIFT;
          bit_cnt <= '0;
        end else gap_cnt <= gap_cnt + 1'b1;
        SHIFT: begin
          sh <= nxt;
          if (bit_cnt == BW'(FRAME_LEN - 1)) begin
            state <= DONE;
            dout <= nxt;
            dout_valid <= 1'b1;
            rx_done_tick <= 1'b1;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        default: begin
          state <= cont ? QUIET : IDLE;
          gap_cnt <= '0;
        end
      endcase
    end
  end
`ifdef ADC_RX_OVERRUN_EN
  always_ff @(posedge sclk) begin
    if (rst) overrun <= 1'b0;
    else if (state == SHIFT && bit_cnt == BW'(FRAME_LEN - 1) && dout_valid && !ack) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_adc_rx_multi.sv
// tb_adc_rx_multi: directed bench with a frame driver and dout scoreboard
module tb_adc_rx_multi;
  logic sclk, rst, rx_en, cont, ack;
  logic [1:0] sdata;
  logic cs, dout_valid, rx_done_tick, busy, overrun;
  logic [23:0] dout;
`ifdef ADC_RX_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif
  adc_rx_multi dut (.sclk(sclk), .rst(rst), .sdata(sdata), .rx_en(rx_en), .cont(cont), .ack(ack),
    .cs(cs), .dout(dout), .dout_valid(dout_valid), .rx_done_tick(rx_done_tick), .busy(busy), .overrun(overrun));
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  int n_assert = 0, n_fail = 0, cyc = 0, t0 = 0, bidx = 0;
  logic [31:0] tx[$];
  logic [23:0] sb[$];
  int tick_q[$];
  logic ovr_q[$];
  logic [127:0] cs_hist;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge sclk);
    #1;
    cyc++;
    if (cyc - t0 >= 0 && cyc - t0 < 128) cs_hist[cyc-t0] = cs;
    if (rx_done_tick === 1'b1) begin
      tick_q.push_back(cyc - t0);
      ovr_q.push_back(overrun);
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("dout", dout, sb.pop_front());
    end
    if (cs === 1'b0 && tx.size() > 0) begin
      sdata = {tx[0][31-bidx], tx[0][15-bidx]};
      bidx++;
      if (bidx == 16) begin
        void'(tx.pop_front());
        bidx = 0;
      end
    end else sdata = 2'($urandom);
  endtask
  task automatic begin_test();
    t0 = cyc;
    cs_hist = '1;
    tick_q.delete();
    ovr_q.delete();
  endtask
  function automatic int lows(input int hi);
    int z = 0;
    for (int i = 1; i <= hi; i++) z += int'(!cs_hist[i]);
    return z;
  endfunction
  initial begin
    int k;
    rst = 1'b1; rx_en = 1'b0; cont = 1'b0; ack = 1'b0; sdata = '0;
    cs_hist = '1;
    repeat (2) step();
    rst = 1'b0;
    step();
    // T1: reset in the middle of a frame
    begin_test();
    rx_en = 1'b1;
    step();
    rx_en = 1'b0;
    repeat (5) step();
    chk("t1_mid_shift_cs", cs, 0);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("t1_cs", cs, 1);
    chk("t1_dout", dout, 0);
    chk("t1_valid", dout_valid, 0);
    chk("t1_busy", busy, 0);
    chk("t1_overrun", overrun, 0);
    chk("t1_tick", rx_done_tick, 0);
    // T2: single shot timing and data
    tx.push_back({16'h0123, 16'h0ABC});
    sb.push_back(24'h123ABC);
    begin_test();
    rx_en = 1'b1;
    step();
    rx_en = 1'b0;
    repeat (24) step();
    chk("t2_ticks", tick_q.size(), 1);
    if (tick_q.size() > 0) chk("t2_tick_cycle", tick_q[0], 18);
    chk("t2_cs_c1", cs_hist[1], 1);
    chk("t2_cs_c2", cs_hist[2], 0);
    chk("t2_cs_c17", cs_hist[17], 0);
    chk("t2_cs_c18", cs_hist[18], 1);
    chk("t2_cs_lows", lows(25), 16);
    chk("t2_busy_end", busy, 0);
    chk("t2_valid", dout_valid, 1);
    // T3: leading bits discarded
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_ack_clears", dout_valid, 0);
    tx.push_back({16'hA5A5, 16'hFABC});
    sb.push_back(24'h5A5ABC);
    begin_test();
    rx_en = 1'b1;
    step();
    rx_en = 1'b0;
    repeat (24) step();
    chk("t3_ticks", tick_q.size(), 1);
    chk("t3_ch0", dout[11:0], 12'hABC);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_ack_clears", dout_valid, 0);
    // T4: continuous mode, cont dropped during the third frame
    tx.push_back({16'hF555, 16'h0001});
    tx.push_back({16'h0AAA, 16'hF002});
    tx.push_back({16'h1234, 16'h8003});
    sb.push_back(24'h555001);
    sb.push_back(24'hAAA002);
    sb.push_back(24'h234003);
    begin_test();
    cont = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      step();
      if (tick_q.size() == 2 && cs === 1'b0) cont = 1'b0;
    end
    chk("t4_ticks", tick_q.size(), 3);
    if (tick_q.size() == 3) begin
      chk("t4_tick0", tick_q[0], 18);
      chk("t4_tick1", tick_q[1], 36);
      chk("t4_tick2", tick_q[2], 54);
      chk("t4_ovr_tick0", ovr_q[0], 0);
      chk("t4_ovr_tick1", ovr_q[1], EXP_OVR);
    end
    chk("t4_cs_c18", cs_hist[18], 1);
    chk("t4_cs_c19", cs_hist[19], 1);
    chk("t4_cs_c20", cs_hist[20], 0);
    chk("t4_cs_c37", cs_hist[37], 1);
    chk("t4_cs_c38", cs_hist[38], 0);
    chk("t4_cs_lows", lows(75), 48);
    chk("t4_busy_end", busy, 0);
    chk("t4_sb_empty", sb.size(), 0);
    // T5: ack in the tick cycle loses to DONE; ack one cycle later clears
    tx.push_back({16'h0777, 16'h0888});
    sb.push_back(24'h777888);
    begin_test();
    rx_en = 1'b1;
    step();
    rx_en = 1'b0;
    k = 0;
    while (rx_done_tick !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk("t5_tick_seen", rx_done_tick, 1);
    ack = 1'b1;
    step();
    chk("t5_valid_ack_at_tick", dout_valid, 1);
    chk("t5_tick_pulse", rx_done_tick, 0);
    step();
    chk("t5_valid_ack_later", dout_valid, 0);
    step();
    ack = 1'b0;
    chk("t5_ack_noop", dout_valid, 0);
    chk("t5_dout_stable", dout, 24'h777888);
    chk("t6_overrun_sticky", overrun, EXP_OVR);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("t6_overrun_rst", overrun, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
